// File: rtl/serial_word_comparator_pkg.sv
// Package serial_cmp_pkg: shared constants and state type for serial_word_comparator.
// Nibble width, FSM state encoding and the cascade seed used at the start of every compare.
package serial_cmp_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  // Cascade seed: "equal so far" before any nibble has been compared
  localparam logic ACC_INIT_G = 1'b0;
  localparam logic ACC_INIT_E = 1'b1;
  localparam logic ACC_INIT_L = 1'b0;

  typedef enum logic {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN
  } state_e;

endpackage : serial_cmp_pkg

// File: rtl/serial_word_comparator_cmp4.sv
// four_bit_comparator: one nibble of a cascaded magnitude compare.
// A strict difference in this nibble decides the result; on equality the cascade
// from the less significant nibbles is passed through unchanged.
module four_bit_comparator
  import serial_cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                gIn_i,
  input  logic                eIn_i,
  input  logic                lIn_i,
  output logic                g_o,
  output logic                e_o,
  output logic                l_o
);

  // This nibble overrides the cascade unless both nibbles are equal
  always_comb begin
    g_o = gIn_i;
    e_o = eIn_i;
    l_o = lIn_i;
    if (a_i > b_i) begin
      g_o = 1'b1;
      e_o = 1'b0;
      l_o = 1'b0;
    end else if (a_i < b_i) begin
      g_o = 1'b0;
      e_o = 1'b0;
      l_o = 1'b1;
    end
  end

endmodule : four_bit_comparator

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: multi-cycle WIDTH-bit magnitude compare using one nibble comparator.
// Operands are latched on start, then one nibble per clock is compared LSB nibble first,
// with the registered g/e/l fed back as the cascade input of the next step.
// Optional build macro SERIAL_CMP_SIGNED_EN: two's complement compare (MSB of both
// latched operands inverted before the top nibble is compared). Timing is identical.
module serial_word_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : gWidthCheck
    $error("serial_word_comparator: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             accG_q, accG_d;
  logic             accE_q, accE_d;
  logic             accL_q, accL_d;
  logic             resG_q, resG_d;
  logic             resE_q, resE_d;
  logic             resL_q, resL_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]    cmpOpA;
  logic [WIDTH-1:0]    cmpOpB;
  logic [NIBBLE_W-1:0] nibA;
  logic [NIBBLE_W-1:0] nibB;
  logic                cmpG;
  logic                cmpE;
  logic                cmpL;

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order
  assign cmpOpA = {~opA_q[WIDTH-1], opA_q[WIDTH-2:0]};
  assign cmpOpB = {~opB_q[WIDTH-1], opB_q[WIDTH-2:0]};
`else
  assign cmpOpA = opA_q;
  assign cmpOpB = opB_q;
`endif

  // Select the nibble pair addressed by the step index
  always_comb begin
    nibA = '0;
    nibB = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibA = cmpOpA[i*NIBBLE_W +: NIBBLE_W];
        nibB = cmpOpB[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  four_bit_comparator uCmp (
    .a_i   (nibA),
    .b_i   (nibB),
    .gIn_i (accG_q),
    .eIn_i (accE_q),
    .lIn_i (accL_q),
    .g_o   (cmpG),
    .e_o   (cmpE),
    .l_o   (cmpL)
  );

  // Next-state logic: accept in IDLE, step one nibble per clock in RUN, publish on the last step
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    accG_d  = accG_q;
    accE_d  = accE_q;
    accL_d  = accL_q;
    resG_d  = resG_q;
    resE_d  = resE_q;
    resL_d  = resL_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          opA_d   = a;
          opB_d   = b;
          idx_d   = '0;
          accG_d  = ACC_INIT_G;
          accE_d  = ACC_INIT_E;
          accL_d  = ACC_INIT_L;
        end
      end
      ST_RUN: begin
        accG_d = cmpG;
        accE_d = cmpE;
        accL_d = cmpL;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          resG_d  = cmpG;
          resE_d  = cmpE;
          resL_d  = cmpL;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand, accumulator and result registers; reset aborts any compare in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      accG_q  <= ACC_INIT_G;
      accE_q  <= ACC_INIT_E;
      accL_q  <= ACC_INIT_L;
      resG_q  <= 1'b0;
      resE_q  <= 1'b0;
      resL_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      accG_q  <= accG_d;
      accE_q  <= accE_d;
      accL_q  <= accL_d;
      resG_q  <= resG_d;
      resE_q  <= resE_d;
      resL_q  <= resL_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign g    = resG_q;
  assign e    = resE_q;
  assign l    = resL_q;

endmodule : serial_word_comparator

// File: tb/tb_serial_word_comparator.sv
// Testbench for serial_word_comparator (WIDTH=16), directed plus randomized operands
// checked against an arithmetic reference compare. Honours SERIAL_CMP_SIGNED_EN.
module tb_serial_word_comparator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         g;
  logic         e;
  logic         l;

  int           checks   = 0;
  int           failures = 0;
  logic [2:0]   lastRes  = 3'b000;

  serial_word_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .g     (g),
    .e     (e),
    .l     (l)
  );

  always #5 clk = ~clk;

  // Reference result {g,e,l} from plain integer comparison
  function automatic logic [2:0] refCompare(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx;
    int sy;
`ifdef SERIAL_CMP_SIGNED_EN
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'({16'h0000, x});
    sy = int'({16'h0000, y});
`endif
    return {sx > sy, sx == sy, sx < sy};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a     = x;
    b     = y;
    start = s;
  endtask

  // Wait (bounded) for done; report cycles waited, busy samples and result stability
  task automatic waitDone(input int budget, output int cycles, output int busyCnt, output logic stable);
    cycles  = 0;
    busyCnt = 0;
    stable  = 1'b1;
    while (done !== 1'b1 && cycles < budget) begin
      if (busy === 1'b1) busyCnt++;
      if ({g, e, l} !== lastRes) stable = 1'b0;
      @(negedge clk);
      cycles++;
    end
  endtask

  // One complete operation with operand scrambling while busy
  task automatic runOp(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int         cyc;
    int         bc;
    logic       stab;
    logic [2:0] exp;
    exp = refCompare(x, y);
    applyStimulus(x, y, 1'b1);
    @(negedge clk);
    applyStimulus(W'($urandom), W'($urandom), 1'b0);
    waitDone(20, cyc, bc, stab);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'd4);
    checkOutput({tag, "_busycycles"}, 32'(bc), 32'd4);
    checkOutput({tag, "_stableduringrun"}, 32'(stab), 32'd1);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_gel"}, 32'({g, e, l}), 32'(exp));
    lastRes = exp;
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
  endtask

  initial begin : main
    int         cyc;
    int         bc;
    logic       stab;
    int         extraDone;
    logic [W-1:0] opA [7];
    logic [W-1:0] opB [7];
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state
    rst_n = 1'b0;
    applyStimulus('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({busy, done, g, e, l}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_after_reset", 32'({busy, done}), 32'd0);

    // Directed cases
    runOp(16'h1234, 16'h1234, "t1_equal");
    checkOutput("t1_const", 32'({g, e, l}), 32'b010);
    runOp(16'h8000, 16'h7FFF, "t2_msb");
`ifdef SERIAL_CMP_SIGNED_EN
    checkOutput("t2_const", 32'({g, e, l}), 32'b001);
`else
    checkOutput("t2_const", 32'({g, e, l}), 32'b100);
`endif
    runOp(16'h000F, 16'h0100, "t3_upperdecides");
    checkOutput("t3_const", 32'({g, e, l}), 32'b001);

    // Start pulse while busy is ignored
    applyStimulus(16'h0002, 16'h0001, 1'b1);
    @(negedge clk);
    applyStimulus(16'h0000, 16'hFFFF, 1'b1);
    @(negedge clk);
    applyStimulus(16'h0000, 16'hFFFF, 1'b0);
    waitDone(20, cyc, bc, stab);
    checkOutput("t4_latency", 32'(cyc), 32'd3);
    checkOutput("t4_gel", 32'({g, e, l}), 32'b100);
    lastRes = 3'b100;
    extraDone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extraDone++;
    end
    checkOutput("t4_no_second_op", 32'(extraDone), 32'd0);

    // Reset in the second RUN cycle aborts asynchronously
    applyStimulus(16'h5555, 16'h1111, 1'b1);
    @(negedge clk);
    applyStimulus(16'h5555, 16'h1111, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("t5_async_reset", 32'({busy, done, g, e, l}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lastRes = 3'b000;
    extraDone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) extraDone++;
    end
    checkOutput("t5_no_done", 32'(extraDone), 32'd0);
    runOp(16'hABCD, 16'hABCD, "t5_after_reset");
    checkOutput("t5_const", 32'({g, e, l}), 32'b010);

    // Start held high: back-to-back ops, done and busy adjacent but disjoint
    for (int k = 0; k < 7; k++) begin
      opA[k] = W'($urandom);
      opB[k] = (k == 2) ? opA[k] : W'($urandom);
    end
    applyStimulus(opA[0], opB[0], 1'b1);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b1);
      waitDone(20, cyc, bc, stab);
      checkOutput($sformatf("t6_latency_%0d", k), 32'(cyc), 32'd4);
      checkOutput($sformatf("t6_stable_%0d", k), 32'(stab), 32'd1);
      checkOutput($sformatf("t6_gel_%0d", k), 32'({g, e, l}), 32'(refCompare(opA[k], opB[k])));
      lastRes = refCompare(opA[k], opB[k]);
      checkOutput($sformatf("t6_busy_at_done_%0d", k), 32'(busy), 32'd0);
      applyStimulus(opA[k+1], opB[k+1], (k < 5) ? 1'b1 : 1'b0);
      @(negedge clk);
      if (k < 5) begin
        checkOutput($sformatf("t6_adjacent_%0d", k), 32'({busy, done}), 32'b10);
      end else begin
        checkOutput("t6_final_idle", 32'({busy, done}), 32'b00);
      end
    end

    // Randomized operands, biased towards equal and near-equal words
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case (k % 4)
        1: rb = ra;
        2: rb = {ra[W-1:4], rb[3:0]};
        3: rb = {rb[W-1:W-4], ra[W-5:0]};
        default: ;
      endcase
      runOp(ra, rb, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_word_comparator
